// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART receive path (and the matching transmitter).
//   Holds the receiver state encoding and the oversampling constants that the
//   sample counter compares against.
//
//   Contents:
//     uart_state_e  - receiver FSM states
//     OVERSAMPLE    - ticks per bit (fixed at 16)
//     MID_SAMPLE    - sample index at the middle of the start bit
//     LAST_SAMPLE   - sample index at which data/parity/stop bits are taken
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam int         OVERSAMPLE  = 16;
  localparam int         SAMPLE_W    = 4;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
//   Free-running divider producing one oversampling tick every CLKS_PER_TICK
//   clocks. A synchronous clear restarts the count so the tick phase can be
//   aligned to an external event (the start edge on the receive side).
//
//   Parameters:
//     CLKS_PER_TICK  clocks per tick, >= 2
//   Ports:
//     clk_i   in  1  clock, rising edge
//     rst_i   in  1  synchronous active-high reset
//     clr_i   in  1  synchronous clear of the divider count
//     tick_o  out 1  one-cycle tick, high in the last count of each period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int CLKS_PER_TICK = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_TICK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_TICK - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   16x oversampling UART receiver: 1 start bit, 8 data bits LSB first,
//   1 stop bit (plus an even parity bit when UART_RX_PARITY_EN is defined).
//   The line is synchronized, a falling edge starts a frame, the start bit is
//   re-checked at mid-bit, and each following bit is taken at sample 15 of
//   its period (mid-bit relative to the start edge).
//
//   Build option:
//     UART_RX_PARITY_EN  adds the PARITY state and the oParityErr output.
//
//   Parameters:
//     CLK_HZ, BAUD   clock frequency and line rate
//     OVERSAMPLE     ticks per bit, must be 16
//   Ports:
//     iClk        in  1  clock, rising edge
//     iRst        in  1  synchronous active-high reset
//     iRx         in  1  asynchronous serial line, idle high
//     oData       out 8  last correctly received byte
//     oValid      out 1  one-cycle strobe, oData updated this cycle
//     oFrameErr   out 1  one-cycle strobe, stop bit sampled low
//     oBusy       out 1  high from start detection until back in IDLE
//     oParityErr  out 1  one-cycle strobe, parity mismatch (option only)
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRx,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oFrameErr,
  output logic       oBusy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       oParityErr
`endif
);

  import uart_pkg::*;

  localparam int CLKS_PER_TICK = CLK_HZ / (BAUD * OVERSAMPLE);

  generate
    if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_bad_oversample
      $error("uart_rx: OVERSAMPLE must be 16");
    end
    if (CLKS_PER_TICK < 2) begin : g_bad_divider
      $error("uart_rx: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
    end
  endgenerate

  // Synchronizer and edge history; all idle high so reset never fakes a start.
  logic rx_s1_q;
  logic rx_s2_q;
  logic rx_prev_q;

  uart_state_e           state_q, state_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  tick;
  logic                  tick_clr;
  logic                  start_edge;
`ifdef UART_RX_PARITY_EN
  logic                  perr_q, perr_d;
  logic                  pbad_q, pbad_d;
`endif

  uart_baud_tick #(
    .CLKS_PER_TICK (CLKS_PER_TICK)
  ) u_tick (
    .clk_i  (iClk),
    .rst_i  (iRst),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  assign start_edge = rx_prev_q && !rx_s2_q;

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    tick_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = 1'b0;
    pbad_d   = pbad_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          // Restart the divider so every later sample is phase-locked to the edge.
          tick_clr = 1'b1;
          sample_d = '0;
          bit_d    = '0;
          state_d  = START;
`ifdef UART_RX_PARITY_EN
          pbad_d   = 1'b0;
`endif
        end
      end

      START: begin
        if (tick) begin
          if (sample_q == MID_SAMPLE) begin
            // Restarting at mid-start puts each sample 15 at the middle of a bit.
            sample_d = '0;
            state_d  = rx_s2_q ? IDLE : DATA;
          end else begin
            sample_d = sample_q + 4'd1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          sample_d = sample_q + 4'd1;
          if (sample_q == LAST_SAMPLE) begin
            shift_d[bit_q] = rx_s2_q;
            bit_d          = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          sample_d = sample_q + 4'd1;
          if (sample_q == LAST_SAMPLE) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            if ((^shift_q) ^ rx_s2_q) begin
              perr_d = 1'b1;
              pbad_d = 1'b1;
            end
            state_d = STOP;
          end
        end
      end
`endif

      STOP: begin
        if (tick) begin
          sample_d = sample_q + 4'd1;
          if (sample_q == LAST_SAMPLE) begin
            if (rx_s2_q) begin
`ifdef UART_RX_PARITY_EN
              if (!pbad_q) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end
`else
              data_d  = shift_q;
              valid_d = 1'b1;
`endif
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_HIGH;
            end
          end
        end
      end

      WAIT_HIGH: begin
        // A break or stuck-low line must end before a new start can be seen.
        if (rx_s2_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      sample_q  <= '0;
      bit_q     <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      pbad_q    <= 1'b0;
`endif
    end else begin
      rx_s1_q   <= iRx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      sample_q  <= sample_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      pbad_q    <= pbad_d;
`endif
    end
  end

  // Shift register is pure datapath; every bit is rewritten before each load.
  always_ff @(posedge iClk) begin
    shift_q <= shift_d;
  end

  assign oData     = data_q;
  assign oValid    = valid_q;
  assign oFrameErr = ferr_q;
  assign oBusy     = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign oParityErr = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Directed bench for uart_rx at CLK_HZ=614_400, BAUD=9600 (4 clocks per tick,
//   64 clocks per bit). Frames are driven bit by bit; a negedge monitor counts
//   output strobes and the scenario tasks compare against hand-derived values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLKS = 64;
  // Strobe cycle, counting the cycle in which iRx falls as cycle 1:
  // 3 cycles to detection, 152 ticks of 4 clocks, then the registered output.
  localparam int STROBE_CYCLE = 3 + 152 * 4 + 1;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iRx;
  logic [7:0] oData;
  logic       oValid;
  logic       oFrameErr;
  logic       oBusy;
`ifdef UART_RX_PARITY_EN
  logic       oParityErr;
`endif

  uart_rx #(
    .CLK_HZ     (614_400),
    .BAUD       (9600),
    .OVERSAMPLE (16)
  ) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iRx       (iRx),
    .oData     (oData),
    .oValid    (oValid),
    .oFrameErr (oFrameErr),
    .oBusy     (oBusy)
`ifdef UART_RX_PARITY_EN
    ,
    .oParityErr(oParityErr)
`endif
  );

  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  int       checks = 0;
  int       errors = 0;
  int       fall_cyc = 0;

  int       valid_cnt = 0;
  int       ferr_cnt = 0;
  int       both_cnt = 0;
  int       perr_cnt = 0;
  int       last_valid_cyc = 0;
  int       last_ferr_cyc = 0;
  logic [7:0] last_valid_data = 8'h00;
  logic [7:0] prev_valid_data = 8'h00;

  always @(negedge iClk) begin
    if (oValid === 1'b1) begin
      valid_cnt       = valid_cnt + 1;
      last_valid_cyc  = cyc;
      prev_valid_data = last_valid_data;
      last_valid_data = oData;
    end
    if (oFrameErr === 1'b1) begin
      ferr_cnt      = ferr_cnt + 1;
      last_ferr_cyc = cyc;
    end
    if (oValid === 1'b1 && oFrameErr === 1'b1) both_cnt = both_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (oParityErr === 1'b1) perr_cnt = perr_cnt + 1;
`endif
  end

  // Called just after a rising edge; returns just after a rising edge.
  task automatic send_bit(input logic b);
    iRx = b;
    repeat (BIT_CLKS) @(posedge iClk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_ok);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ ~par_ok);
`else
    if (par_ok === 1'bx) iRx = 1'b0;
`endif
    send_bit(stop_b);
  endtask

  task automatic idle(input int n);
    iRx = 1'b1;
    repeat (n) @(posedge iClk);
    #1;
  endtask

  task automatic test_reset;
    iRx  = 1'b1;
    iRst = 1'b1;
    repeat (2) @(posedge iClk);
    @(negedge iClk);
    checks++; if (oData !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", oData); end
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", oValid); end
    checks++; if (oFrameErr !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", oFrameErr); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    @(posedge iClk); #1;
    iRst = 1'b0;
    idle(10);
  endtask

  task automatic test_frame_a5;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL a5_valid_count: got %0d want 1", valid_cnt - v0); end
    checks++; if (last_valid_data !== 8'hA5) begin errors++; $display("FAIL a5_strobe_data: got %h want a5", last_valid_data); end
    checks++; if (oData !== 8'hA5) begin errors++; $display("FAIL a5_odata: got %h want a5", oData); end
    checks++; if (last_valid_cyc - fall_cyc + 1 !== STROBE_CYCLE) begin errors++;
      $display("FAIL a5_latency: got %0d want %0d", last_valid_cyc - fall_cyc + 1, STROBE_CYCLE); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL a5_no_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL a5_busy_idle: got %b want 0", oBusy); end
  endtask

  task automatic test_glitch;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    iRx = 1'b0;
    repeat (16) @(posedge iClk);
    #1;
    iRx = 1'b1;
    @(negedge iClk);
    checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL glitch_busy_set: got %b want 1", oBusy); end
    repeat (20) @(posedge iClk);
    @(negedge iClk);
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL glitch_busy_clear: got %b want 0", oBusy); end
    @(posedge iClk); #1;
    idle(200);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_no_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_no_ferr: got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (200 - BIT_CLKS) @(posedge iClk);
    @(negedge iClk);
    checks++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
    checks++; if (last_ferr_cyc - fall_cyc + 1 !== STROBE_CYCLE) begin errors++;
      $display("FAIL ferr_latency: got %0d want %0d", last_ferr_cyc - fall_cyc + 1, STROBE_CYCLE); end
    checks++; if (oData !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept: got %h want a5", oData); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL ferr_no_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL ferr_busy_held: got %b want 1", oBusy); end
    @(posedge iClk); #1;
    idle(6);
    @(negedge iClk);
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b want 0", oBusy); end
    @(posedge iClk); #1;
    idle(20);
  endtask

  task automatic test_back_to_back;
    int v0, f0, b0;
    v0 = valid_cnt; f0 = ferr_cnt; b0 = both_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    idle(20);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL b2b_valid_count: got %0d want 2", valid_cnt - v0); end
    checks++; if (prev_valid_data !== 8'h00) begin errors++; $display("FAIL b2b_first_data: got %h want 00", prev_valid_data); end
    checks++; if (last_valid_data !== 8'hFF) begin errors++; $display("FAIL b2b_second_data: got %h want ff", last_valid_data); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_no_ferr: got %0d want 0", ferr_cnt - f0); end
    checks++; if (both_cnt - b0 !== 0) begin errors++; $display("FAIL b2b_exclusive: got %0d want 0", both_cnt - b0); end
  endtask

  task automatic test_reset_abort;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    // Start bit and data bits 0..3 of 0x00, then reset inside data bit 4.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    iRx = 1'b0;
    repeat (10) @(posedge iClk);
    #1;
    iRst = 1'b1;
    iRx  = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    @(negedge iClk);
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", oBusy); end
    checks++; if (oData !== 8'h00) begin errors++; $display("FAIL abort_data_reset: got %h want 00", oData); end
    @(posedge iClk); #1;
    idle(700);
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL abort_no_ferr: got %0d want 0", ferr_cnt - f0); end
    send_frame(8'h81, 1'b1, 1'b1);
    idle(20);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL after_abort_valid: got %0d want 1", valid_cnt - v0); end
    checks++; if (oData !== 8'h81) begin errors++; $display("FAIL after_abort_data: got %h want 81", oData); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int v0, p0;
    v0 = valid_cnt; p0 = perr_cnt;
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    checks++; if (perr_cnt - p0 !== 1) begin errors++; $display("FAIL parity_err_count: got %0d want 1", perr_cnt - p0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL parity_no_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (oData !== 8'h81) begin errors++; $display("FAIL parity_data_kept: got %h want 81", oData); end
  endtask
`endif

  initial begin
    iRst = 1'b1;
    iRx  = 1'b1;
    test_reset;
    test_frame_a5;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_abort;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver that recovers 8-bit frames (1 start, 8 data LSB first, 1 stop) from an asynchronous line using 16× oversampling. It is the receiving end of the team's serial transmitter and replaces the unsampled loopback receiver. Recovered bytes go to the binary-to-BCD separator and the 7-segment path, qualified by a one-cycle valid strobe.

## Interface

Parameters:
- CLK_HZ, 50_000_000: system clock frequency in Hz
- BAUD, 9600: line bit rate
- OVERSAMPLE, 16: ticks per bit; fixed at 16; any other value is an elaboration error
- CLKS_PER_TICK, CLK_HZ/(BAUD*OVERSAMPLE): derived, truncating division; must be ≥ 2

Ports (one clock; reset is synchronous and active-high):
- iClk  in  1  system clock, rising edge
- iRst  in  1  synchronous active-high reset
- iRx  in  1  asynchronous serial line, idle high
- oData  out  8  last correctly received byte
- oValid  out  1  one-cycle strobe; oData is new this cycle
- oFrameErr  out  1  one-cycle strobe; stop bit sampled low
- oBusy  out  1  high from start detection until return to IDLE

## Operation

- iRx passes through a 2-flop synchronizer whose flops reset to 1, followed by one edge-history flop.
- Tick generator: counter 0..CLKS_PER_TICK-1, width $clog2(CLKS_PER_TICK). Emits a one-cycle tick on wrap. Cleared on start detection so that tick phase aligns to the start edge.
- Sample counter: 4 bits, wraps at 16. Bit counter: 3 bits.
- States:
  - IDLE: on a synchronized 1→0 transition, clear the tick and sample counters, set oBusy, and go to START.
  - START: at sample 7 (mid-bit), if the line is low, clear the sample counter and go to DATA. If the line is high, treat it as a glitch and go to IDLE with no strobe.
  - DATA: at each sample 15, shift the line into bit (bit counter) LSB first. After bit 7, go to STOP, or to PARITY when UART_RX_PARITY_EN is defined.
  - STOP: at sample 15, if the line is high, load oData from the shift register, pulse oValid, and go to IDLE. If the line is low, pulse oFrameErr, leave oData unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronized line is high, then go to IDLE. This covers a break or stuck-low line.
- A new start edge is accepted in the cycle after the return to IDLE, so back-to-back frames need no extra idle time.
- iRst at any point, including mid-frame, takes effect on the next edge: state IDLE, all counters cleared, partial byte discarded, no strobe.

## Timing

- Reset values: oData=8'h00, oValid=0, oFrameErr=0, oBusy=0, synchronizer=1.
- Start detection occurs 3 iClk cycles after iRx falls (2 synchronizer cycles plus the edge-history flop).
- Data bit n is sampled (24+16n) ticks after start detection.
- The stop bit is sampled 152 ticks after detection. oValid or oFrameErr is registered and asserts in the next cycle.
- Strobes last exactly one cycle. oValid and oFrameErr are never asserted in the same cycle.
- oBusy deasserts in the same cycle as the oValid strobe. On the error path it deasserts on leaving WAIT_HIGH.

## Configuration

UART_RX_PARITY_EN:
- Defined:
  - Adds a PARITY state and an output oParityErr (out, 1, one-cycle strobe, reset 0).
  - The parity bit follows the data and is sampled at sample 15. Even parity: the XOR of the 8 data bits and the parity bit must be 0.
  - On mismatch: pulse oParityErr, suppress oValid, leave oData unchanged. The stop bit is still checked.
- Undefined: 10-bit frames; the port and state do not exist.

## Structure

- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH)
  - OVERSAMPLE=16
  - MID_SAMPLE=7
  - LAST_SAMPLE=15
- One sub-module: uart_baud_tick (tick generator with synchronous clear), reusable by the transmitter.

## Test plan

Bench parameters: CLK_HZ=614_400, BAUD=9600, so CLKS_PER_TICK=4 and one bit period is 64 clocks.

- Reset: iRst high for 2 cycles with iRx=1 → all outputs at their reset values; oBusy=0.
- Frame 0xA5 with a valid stop bit → exactly one oValid, with oData=8'hA5, on cycle 3+152·4+1 after iRx falls; oFrameErr never asserted.
- Glitch: iRx low for 16 clocks, then high → no strobe; oBusy falls by the mid-start sample.
- Stop bit driven low for frame 0x3C, line held low for 200 clocks → one oFrameErr, oData keeps its previous value, oBusy stays high until the line rises.
- Back-to-back 0x00 then 0xFF with no idle gap → two oValid strobes, with data 0x00 then 0xFF.
- iRst pulsed at data bit 4, then a clean 0x81 frame → no strobe for the aborted frame, then oData=8'h81. With UART_RX_PARITY_EN defined, 0x81 sent with parity 1 → oParityErr and no oValid.
